r_id_restore_unit: RTL and testbench



---
 rtl/r_id_restore_unit_pkg.sv | 16 +
 rtl/r_id_restore_unit_cache.sv | 34 +++
 rtl/r_id_restore_unit.sv | 135 +++++++++++++
 tb/tb_r_id_restore_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/r_id_restore_unit_pkg.sv
// Shared widths and FSM encoding for the R-path ID restore stage.
package r_id_restore_unit_pkg;

    localparam int unsigned DEF_ID_WIDTH        = 4;
    localparam int unsigned DEF_DATA_WIDTH      = 32;
    localparam int unsigned DEF_RESP_WIDTH      = 2;
    localparam int unsigned DEF_BEAT_CNT_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_SEND   = 2'd2,
        ST_FREE   = 2'd3
    } state_t;

endpackage

// File: rtl/r_id_restore_unit_cache.sv
// Single-entry UID -> original ID cache with registered contents and a combinational match.
module r_id_restore_unit_cache #(
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [ID_WIDTH-1:0] load_uid,
    input  logic [ID_WIDTH-1:0] load_oid,
    input  logic                inval,
    input  logic [ID_WIDTH-1:0] query_uid,
    output logic                valid,
    output logic [ID_WIDTH-1:0] uid,
    output logic [ID_WIDTH-1:0] oid,
    output logic                hit_c
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            uid   <= '0;
            oid   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            uid   <= load_uid;
            oid   <= load_oid;
        end else if (inval) begin
            valid <= 1'b0;
        end
    end

    assign hit_c = valid && (query_uid == uid);

endmodule

// File: rtl/r_id_restore_unit.sv
// Restores the original R-channel ID from a UID tag, one beat in flight, freeing the UID on the last beat.
module r_id_restore_unit
    import r_id_restore_unit_pkg::*;
#(
    parameter int unsigned ID_WIDTH       = DEF_ID_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned RESP_WIDTH     = DEF_RESP_WIDTH,
    parameter int unsigned BEAT_CNT_WIDTH = DEF_BEAT_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      r_in_valid,
    output logic                      r_in_ready,
    input  logic [ID_WIDTH-1:0]       r_in_id,
    input  logic [DATA_WIDTH-1:0]     r_in_data,
    input  logic [RESP_WIDTH-1:0]     r_in_resp,
    input  logic                      r_in_last,
    output logic                      r_out_valid,
    input  logic                      r_out_ready,
    output logic [ID_WIDTH-1:0]       r_out_id,
    output logic [DATA_WIDTH-1:0]     r_out_data,
    output logic [RESP_WIDTH-1:0]     r_out_resp,
    output logic                      r_out_last,
    output logic                      lookup_req,
    output logic [ID_WIDTH-1:0]       lookup_uid,
    input  logic                      lookup_gnt,
    input  logic [ID_WIDTH-1:0]       orig_id,
    output logic                      free_req,
    output logic [ID_WIDTH-1:0]       free_uid,
    input  logic                      free_gnt,
    output logic [BEAT_CNT_WIDTH-1:0] beat_cnt
);

    state_t                  state, state_nxt;
    logic                    hs_in, hs_out;
    logic                    cache_load, cache_inval, cache_hit_c, cache_valid;
    logic [ID_WIDTH-1:0]     cache_uid, cache_oid;
    logic [ID_WIDTH-1:0]     lat_uid;
    logic [DATA_WIDTH-1:0]   lat_data;
    logic [RESP_WIDTH-1:0]   lat_resp;
    logic                    lat_last;

    assign hs_in  = r_in_valid & r_in_ready;
    assign hs_out = r_out_valid & r_out_ready;

    r_id_restore_unit_cache #(.ID_WIDTH(ID_WIDTH)) u_cache (
        .clk       (clk),
        .rst       (rst),
        .load      (cache_load),
        .load_uid  (lat_uid),
        .load_oid  (orig_id),
        .inval     (cache_inval),
        .query_uid (r_in_id),
        .valid     (cache_valid),
        .uid       (cache_uid),
        .oid       (cache_oid),
        .hit_c     (cache_hit_c)
    );

    // Next-state and cache control; grants outside their state fall through to defaults.
    always_comb begin
        state_nxt   = state;
        cache_load  = 1'b0;
        cache_inval = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hs_in) state_nxt = cache_hit_c ? ST_SEND : ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (lookup_gnt) begin
                    cache_load = 1'b1;
                    state_nxt  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (hs_out) state_nxt = lat_last ? ST_FREE : ST_IDLE;
            end
            ST_FREE: begin
                if (free_gnt) begin
                    cache_inval = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; handshake/request outputs are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            lookup_req  <= 1'b0;
            free_req    <= 1'b0;
        end else begin
            state       <= state_nxt;
            r_in_ready  <= (state_nxt == ST_IDLE);
            r_out_valid <= (state_nxt == ST_SEND);
            lookup_req  <= (state_nxt == ST_LOOKUP);
            free_req    <= (state_nxt == ST_FREE);
        end
    end

    // Beat capture and per-burst counter; a cache (re)load starts a fresh burst count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_uid  <= '0;
            lat_data <= '0;
            lat_resp <= '0;
            lat_last <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (hs_in) begin
                lat_uid  <= r_in_id;
                lat_data <= r_in_data;
                lat_resp <= r_in_resp;
                lat_last <= r_in_last;
            end
            if (cache_load || cache_inval) begin
                beat_cnt <= '0;
            end else if (hs_out) begin
                beat_cnt <= beat_cnt + BEAT_CNT_WIDTH'(1);
            end
        end
    end

    assign r_out_id   = cache_oid;
    assign r_out_data = lat_data;
    assign r_out_resp = lat_resp;
    assign r_out_last = lat_last;
    assign lookup_uid = lat_uid;
    assign free_uid   = cache_uid;

endmodule

// File: tb/tb_r_id_restore_unit.sv
// Directed bench for r_id_restore_unit: vector table of beats plus backpressure, delayed-grant and reset sequences.
module tb_r_id_restore_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_in_valid, r_in_ready, r_in_last;
    logic [3:0]  r_in_id;
    logic [31:0] r_in_data;
    logic [1:0]  r_in_resp;
    logic        r_out_valid, r_out_ready, r_out_last;
    logic [3:0]  r_out_id;
    logic [31:0] r_out_data;
    logic [1:0]  r_out_resp;
    logic        lookup_req, lookup_gnt, free_req, free_gnt;
    logic [3:0]  lookup_uid, orig_id, free_uid;
    logic [7:0]  beat_cnt;

    int nvec = 0;
    int nerr = 0;
    int overlap_cnt = 0;
    int lookup_pulses = 0;
    logic lookup_req_d = 1'b0;

    always #5 clk = ~clk;

    r_id_restore_unit dut (
        .clk(clk), .rst(rst),
        .r_in_valid(r_in_valid), .r_in_ready(r_in_ready), .r_in_id(r_in_id),
        .r_in_data(r_in_data), .r_in_resp(r_in_resp), .r_in_last(r_in_last),
        .r_out_valid(r_out_valid), .r_out_ready(r_out_ready), .r_out_id(r_out_id),
        .r_out_data(r_out_data), .r_out_resp(r_out_resp), .r_out_last(r_out_last),
        .lookup_req(lookup_req), .lookup_uid(lookup_uid), .lookup_gnt(lookup_gnt),
        .orig_id(orig_id), .free_req(free_req), .free_uid(free_uid),
        .free_gnt(free_gnt), .beat_cnt(beat_cnt)
    );

    // Watch for request overlap and count lookup_req rising edges.
    always @(negedge clk) begin
        if (lookup_req && free_req) overlap_cnt++;
        if (lookup_req && !lookup_req_d) lookup_pulses++;
        lookup_req_d <= lookup_req;
    end

    typedef struct {
        logic [3:0]  uid;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  oid;
        logic        exp_lookup;
        logic [3:0]  exp_id;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat with r_out_ready=1, grant any lookup immediately, complete send and free.
    task automatic apply_vec(input vec_t v);
        check("in_ready_before", 32'(r_in_ready), 32'd1);
        r_in_valid = 1'b1; r_in_id = v.uid; r_in_data = v.data;
        r_in_resp = v.resp; r_in_last = v.last;
        step();
        r_in_valid = 1'b0;
        check("lookup_req", 32'(lookup_req), 32'(v.exp_lookup));
        check("out_valid_hit", 32'(r_out_valid), 32'(!v.exp_lookup));
        if (v.exp_lookup) begin
            check("lookup_uid", 32'(lookup_uid), 32'(v.uid));
            lookup_gnt = 1'b1; orig_id = v.oid;
            step();
            lookup_gnt = 1'b0; orig_id = 4'h0;
            check("out_valid_miss", 32'(r_out_valid), 32'd1);
        end
        check("out_id", 32'(r_out_id), 32'(v.exp_id));
        check("out_data", r_out_data, v.data);
        check("out_resp", 32'(r_out_resp), 32'(v.resp));
        check("out_last", 32'(r_out_last), 32'(v.last));
        check("in_ready_busy", 32'(r_in_ready), 32'd0);
        step();
        check("beat_cnt", 32'(beat_cnt), 32'(v.exp_cnt));
        if (v.last) begin
            check("free_req", 32'(free_req), 32'd1);
            check("free_uid", 32'(free_uid), 32'(v.uid));
            free_gnt = 1'b1;
            step();
            free_gnt = 1'b0;
            check("beat_cnt_cleared", 32'(beat_cnt), 32'd0);
        end else begin
            check("no_free", 32'(free_req), 32'd0);
        end
        check("in_ready_after", 32'(r_in_ready), 32'd1);
    endtask

    initial begin
        int p0;
        logic [31:0] held_data;

        vecs[0] = '{4'd3, 32'hA5A5_0001, 2'd0, 1'b1, 4'd9, 1'b1, 4'd9, 8'd1};
        vecs[1] = '{4'd5, 32'h0000_1111, 2'd1, 1'b0, 4'd2, 1'b1, 4'd2, 8'd1};
        vecs[2] = '{4'd5, 32'h0000_2222, 2'd0, 1'b0, 4'd2, 1'b0, 4'd2, 8'd2};
        vecs[3] = '{4'd5, 32'h0000_3333, 2'd2, 1'b0, 4'd2, 1'b0, 4'd2, 8'd3};
        vecs[4] = '{4'd5, 32'h0000_4444, 2'd3, 1'b1, 4'd2, 1'b0, 4'd2, 8'd4};
        vecs[5] = '{4'd1, 32'hDEAD_0001, 2'd0, 1'b0, 4'd4, 1'b1, 4'd4, 8'd1};
        vecs[6] = '{4'd6, 32'hBEEF_0006, 2'd0, 1'b1, 4'd7, 1'b1, 4'd7, 8'd1};

        rst = 1'b0;
        r_in_valid = 1'b0; r_in_id = '0; r_in_data = '0; r_in_resp = '0; r_in_last = 1'b0;
        r_out_ready = 1'b1; lookup_gnt = 1'b0; orig_id = '0; free_gnt = 1'b0;
        step(); step();
        check("rst_in_ready", 32'(r_in_ready), 32'd1);
        check("rst_out_valid", 32'(r_out_valid), 32'd0);
        check("rst_lookup_req", 32'(lookup_req), 32'd0);
        check("rst_free_req", 32'(free_req), 32'd0);
        check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            if (i == 1) p0 = lookup_pulses;
            apply_vec(vecs[i]);
            if (i == 4) check("burst_lookup_pulses", 32'(lookup_pulses - p0), 32'd1);
        end

        // Backpressure: five cycles of r_out_ready=0 in SEND.
        r_out_ready = 1'b0;
        r_in_valid = 1'b1; r_in_id = 4'd8; r_in_data = 32'h1234_5678; r_in_resp = 2'd2; r_in_last = 1'b0;
        step();
        r_in_valid = 1'b0;
        lookup_gnt = 1'b1; orig_id = 4'hC;
        step();
        lookup_gnt = 1'b0;
        held_data = 32'h1234_5678;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(r_out_valid), 32'd1);
            check("bp_data", r_out_data, held_data);
            check("bp_id", 32'(r_out_id), 32'hC);
            check("bp_in_ready", 32'(r_in_ready), 32'd0);
            step();
        end
        r_out_ready = 1'b1;
        step();
        check("bp_beat_cnt", 32'(beat_cnt), 32'd1);
        check("bp_released", 32'(r_in_ready), 32'd1);

        // Delayed grants: lookup after 3 cycles, free after 4.
        r_in_valid = 1'b1; r_in_id = 4'hA; r_in_data = 32'h0BAD_F00D; r_in_resp = 2'd0; r_in_last = 1'b1;
        step();
        r_in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("dl_lookup_hold", 32'(lookup_req), 32'd1);
            check("dl_no_valid", 32'(r_out_valid), 32'd0);
            step();
        end
        lookup_gnt = 1'b1; orig_id = 4'hB;
        step();
        lookup_gnt = 1'b0;
        check("dl_out_id", 32'(r_out_id), 32'hB);
        step();
        for (int c = 0; c < 4; c++) begin
            check("dl_free_hold", 32'(free_req), 32'd1);
            check("dl_free_uid", 32'(free_uid), 32'hA);
            step();
        end
        free_gnt = 1'b1;
        step();
        free_gnt = 1'b0;
        check("dl_free_done", 32'(free_req), 32'd0);
        check("dl_in_ready", 32'(r_in_ready), 32'd1);

        // Reset mid-lookup: cache holds UID 2, then a UID 4 lookup is interrupted.
        apply_vec('{4'd2, 32'h2222_0002, 2'd0, 1'b0, 4'd5, 1'b1, 4'd5, 8'd1});
        r_in_valid = 1'b1; r_in_id = 4'd4; r_in_data = 32'h4444_0004; r_in_last = 1'b0;
        step();
        r_in_valid = 1'b0;
        check("mr_in_lookup", 32'(lookup_req), 32'd1);
        rst = 1'b0;
        #1;
        check("mr_lookup_req", 32'(lookup_req), 32'd0);
        check("mr_out_valid", 32'(r_out_valid), 32'd0);
        check("mr_in_ready", 32'(r_in_ready), 32'd1);
        check("mr_beat_cnt", 32'(beat_cnt), 32'd0);
        step();
        rst = 1'b1;
        step();
        // UID 2 would hit had the cache survived; it must look up again.
        apply_vec('{4'd2, 32'h2222_0003, 2'd1, 1'b1, 4'd5, 1'b1, 4'd5, 8'd1});

        check("req_overlap", 32'(overlap_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
